// File: rtl/loop_pin_sequencer.sv
// -----------------------------------------------------------------------------
// loop_pin_sequencer
//
// Drives the side-input enable pins of a chained and2/nand2 combinational-loop
// test structure through a single sweep. Step 0 closes the loop (all pins
// high); step s (1..NPIN) opens the loop at pin s-1 only. Each step waits
// SETTLE cycles for the loop to react, then counts toggles on the synchronized
// loop node for W cycles, then evaluates the count for one cycle.
//
// Optional feature macro: LOOP_PIN_SEQ_ABORT_EN
//   When defined, an extra 'abort' input cancels a sweep in progress, returns
//   to IDLE with the loop held open and clears all results (no done pulse).
//
// Ports:
//   clk         in   1      clock
//   rst         in   1      asynchronous active-high reset
//   abort       in   1      cancel sweep (only with LOOP_PIN_SEQ_ABORT_EN)
//   start       in   1      begin sweep; sampled in IDLE only
//   win_len     in   WIN_W  observation window length (0 treated as 1),
//                           sampled at start
//   obs         in   1      asynchronous loop node under observation
//   pin_out     out  NPIN   enable pins driven to the loop
//   busy        out  1      sweep in progress
//   done        out  1      one-cycle pulse at sweep end
//   osc_flag    out  1      loop oscillated with all pins closed (step 0)
//   break_mask  out  NPIN   bit k set when opening pin k stopped oscillation
//   toggle_cnt  out  WIN_W  toggles counted in step 0, saturating
//   state_dbg   out  3      current FSM state encoding (debug visibility)
//
// Handshake: start is a level sampled only while IDLE; a start seen in any
// other state is dropped, there is no ready/back-pressure.
// -----------------------------------------------------------------------------
module loop_pin_sequencer #(
   parameter int NPIN   = 9,
   parameter int WIN_W  = 8,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst,
`ifdef LOOP_PIN_SEQ_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [WIN_W-1:0]  win_len,
   input  logic              obs,
   output logic [NPIN-1:0]   pin_out,
   output logic              busy,
   output logic              done,
   output logic              osc_flag,
   output logic [NPIN-1:0]   break_mask,
   output logic [WIN_W-1:0]  toggle_cnt,
   output logic [2:0]        state_dbg
);

   // Step index holds 0..NPIN; settle counter holds 0..SETTLE-1.
   localparam int S_W   = (NPIN < 2) ? 1 : $clog2(NPIN + 1);
   localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_OBSERVE = 3'd2,
      ST_EVAL    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [S_W-1:0]      s_q, s_d;
   logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
   logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic [WIN_W-1:0]    cnt_q, cnt_d;
   logic                osc_q, osc_d;
   logic [NPIN-1:0]     mask_q, mask_d;
   logic [WIN_W-1:0]    tcnt_q, tcnt_d;
   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                prev_q, prev_d;
   logic                toggle;
   logic                abort_hit;

   assign toggle = (sync2_q != prev_q);

`ifdef LOOP_PIN_SEQ_ABORT_EN
   assign abort_hit = abort && ((state_q == ST_SETTLE) ||
                                (state_q == ST_OBSERVE) ||
                                (state_q == ST_EVAL));
`else
   assign abort_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      set_cnt_d = set_cnt_q;
      win_cnt_d = win_cnt_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      osc_d     = osc_q;
      mask_d    = mask_q;
      tcnt_d    = tcnt_q;
      sync1_d   = obs;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               win_d     = (win_len == '0) ? WIN_W'(1) : win_len;
               osc_d     = 1'b0;
               mask_d    = '0;
               tcnt_d    = '0;
               cnt_d     = '0;
               s_d       = '0;
               set_cnt_d = '0;
               state_d   = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (set_cnt_q == SET_W'(SETTLE - 1)) begin
               win_cnt_d = '0;
               // Load prev with the value sync2 takes on this same edge, so the
               // first window cycle can never see a toggle.
               prev_d    = sync1_q;
               state_d   = ST_OBSERVE;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end

         ST_OBSERVE: begin
            if (toggle && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (win_cnt_q == (win_q - 1'b1)) begin
               state_d = ST_EVAL;
            end else begin
               win_cnt_d = win_cnt_q + 1'b1;
            end
         end

         ST_EVAL: begin
            if (s_q == '0) begin
               tcnt_d = cnt_q;
               osc_d  = (cnt_q >= WIN_W'(2));
            end else begin
               // Opening pin s-1 "breaks" the loop only if it was oscillating
               // with every pin closed and now stays quiet.
               for (int k = 0; k < NPIN; k++) begin
                  if (s_q == S_W'(k + 1)) begin
                     mask_d[k] = osc_q && (cnt_q < WIN_W'(2));
                  end
               end
            end
            cnt_d = '0;
            if (s_q == S_W'(NPIN)) begin
               state_d = ST_DONE;
            end else begin
               s_d       = s_q + 1'b1;
               set_cnt_d = '0;
               state_d   = ST_SETTLE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides any transition computed above.
      if (abort_hit) begin
         state_d = ST_IDLE;
         osc_d   = 1'b0;
         mask_d  = '0;
         tcnt_d  = '0;
         cnt_d   = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         s_q       <= '0;
         set_cnt_q <= '0;
         win_cnt_q <= '0;
         win_q     <= '0;
         cnt_q     <= '0;
         osc_q     <= 1'b0;
         mask_q    <= '0;
         tcnt_q    <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         set_cnt_q <= set_cnt_d;
         win_cnt_q <= win_cnt_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         osc_q     <= osc_d;
         mask_q    <= mask_d;
         tcnt_q    <= tcnt_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      pin_out = '0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_SETTLE, ST_OBSERVE, ST_EVAL: begin
            busy = 1'b1;
            // Step 0 drives all ones; step s clears only bit s-1.
            for (int k = 0; k < NPIN; k++) begin
               pin_out[k] = (s_q != S_W'(k + 1));
            end
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            pin_out = '0;
         end
      endcase
   end

   assign osc_flag   = osc_q;
   assign break_mask = mask_q;
   assign toggle_cnt = tcnt_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_loop_pin_sequencer.sv
// -----------------------------------------------------------------------------
// tb_loop_pin_sequencer
//
// Directed bench for loop_pin_sequencer (NPIN=9, WIN_W=8, SETTLE=4). A small
// behavioural loop model drives obs from pin_out on each falling edge. Cycle c
// of a sweep is the clock period after the c-th rising edge following the
// cycle in which start was raised; inputs change and outputs are sampled on
// falling edges.
// -----------------------------------------------------------------------------
module tb_loop_pin_sequencer;

   localparam int NPIN   = 9;
   localparam int WIN_W  = 8;
   localparam int SETTLE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [WIN_W-1:0]  win_len;
   logic              obs = 1'b0;
   logic [NPIN-1:0]   pin_out;
   logic              busy;
   logic              done;
   logic              osc_flag;
   logic [NPIN-1:0]   break_mask;
   logic [WIN_W-1:0]  toggle_cnt;
   logic [2:0]        state_dbg;
`ifdef LOOP_PIN_SEQ_ABORT_EN
   logic              abort;
`endif

   int total = 0;
   int bad   = 0;

   // Loop model selector: 0 obs held low, 1 always toggling,
   // 2 toggles iff all pins high, 3 toggles iff pin 3 and pin 5 high.
   int obs_mode = 0;

   int first_busy, last_busy, done_cyc, done_cnt;
   logic [NPIN-1:0] pin_log [0:2700];

   loop_pin_sequencer #(.NPIN(NPIN), .WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef LOOP_PIN_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .start      (start),
      .win_len    (win_len),
      .obs        (obs),
      .pin_out    (pin_out),
      .busy       (busy),
      .done       (done),
      .osc_flag   (osc_flag),
      .break_mask (break_mask),
      .toggle_cnt (toggle_cnt),
      .state_dbg  (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Loop-under-test model
   always @(negedge clk) begin
      case (obs_mode)
         1:       obs = ~obs;
         2:       obs = (&pin_out) ? ~obs : 1'b0;
         3:       obs = (pin_out[3] & pin_out[5]) ? ~obs : 1'b0;
         default: obs = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Raise start in cycle 0, then record busy/done/pin_out for cycles
   // 1..max_cyc. A second start is raised at ign_cyc (ignored by the DUT) and
   // win_len is scrambled mid-sweep. abort_cyc < 0 means no abort.
   task automatic run_sweep(input logic [WIN_W-1:0] wl, input int ign_cyc,
                            input int abort_cyc, input int max_cyc);
      win_len    = wl;
      start      = 1'b1;
      first_busy = -1;
      last_busy  = -1;
      done_cyc   = -1;
      done_cnt   = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         start = (c == ign_cyc);
`ifdef LOOP_PIN_SEQ_ABORT_EN
         abort = (c == abort_cyc);
`else
         if (c == abort_cyc) start = 1'b0;
`endif
         if (c == 2) win_len = WIN_W'($urandom_range(0, 255));
         if (busy) begin
            if (first_busy < 0) first_busy = c;
            last_busy = c;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         pin_log[c] = pin_out;
      end
      start = 1'b0;
`ifdef LOOP_PIN_SEQ_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   initial begin
      logic [NPIN-1:0] exp_pin;

      rst     = 1'b1;
      start   = 1'b0;
      win_len = 8'd8;
`ifdef LOOP_PIN_SEQ_ABORT_EN
      abort   = 1'b0;
`endif
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_pin_out",    32'(pin_out),    32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      check("rst_done",       32'(done),       32'h0);
      check("rst_osc_flag",   32'(osc_flag),   32'h0);
      check("rst_break_mask", 32'(break_mask), 32'h0);
      check("rst_toggle_cnt", 32'(toggle_cnt), 32'h0);
      check("rst_state",      32'(state_dbg),  32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: quiet loop, start at cycle 50 ignored
      obs_mode = 0;
      run_sweep(8'd8, 50, -1, 140);
      check("t1_first_busy", 32'(first_busy), 32'd1);
      check("t1_last_busy",  32'(last_busy),  32'd130);
      check("t1_done_cyc",   32'(done_cyc),   32'd131);
      check("t1_done_cnt",   32'(done_cnt),   32'd1);
      check("t1_osc_flag",   32'(osc_flag),   32'h0);
      check("t1_break_mask", 32'(break_mask), 32'h000);
      check("t1_toggle_cnt", 32'(toggle_cnt), 32'd0);
      check("t1_idle_pins",  32'(pin_log[140]), 32'h000);
      repeat (3) @(negedge clk);

      // 2: always toggling, start during DONE ignored
      obs_mode = 1;
      run_sweep(8'd8, 131, -1, 140);
      check("t2_last_busy",  32'(last_busy),  32'd130);
      check("t2_done_cnt",   32'(done_cnt),   32'd1);
      check("t2_osc_flag",   32'(osc_flag),   32'h1);
      check("t2_toggle_cnt", 32'(toggle_cnt), 32'd7);
      check("t2_break_mask", 32'(break_mask), 32'h000);
      repeat (3) @(negedge clk);

      // 3: oscillates only with every pin closed
      obs_mode = 2;
      run_sweep(8'd8, -1, -1, 140);
      check("t3_osc_flag",   32'(osc_flag),   32'h1);
      check("t3_break_mask", 32'(break_mask), 32'h1FF);
      check("t3_done_cyc",   32'(done_cyc),   32'd131);
      repeat (3) @(negedge clk);

      // 4: oscillates iff pin 3 and pin 5 high; check step pin patterns
      obs_mode = 3;
      run_sweep(8'd8, -1, -1, 140);
      check("t4_osc_flag",   32'(osc_flag),   32'h1);
      check("t4_toggle_cnt", 32'(toggle_cnt), 32'd7);
      check("t4_break_mask", 32'(break_mask), 32'h028);
      for (int s = 0; s <= NPIN; s++) begin
         exp_pin = 9'h1FF;
         if (s > 0) exp_pin[s-1] = 1'b0;
         check($sformatf("t4_pins_step%0d", s), 32'(pin_log[1 + s*13]), 32'(exp_pin));
      end
      check("t4_done_pins",  32'(pin_log[131]), 32'h000);
      repeat (3) @(negedge clk);

      // 5: reset during step 4 OBSERVE (cycle 60), restart at cycle 200
      run_sweep(8'd8, -1, -1, 60);
      check("t5_pre_rst_osc",  32'(osc_flag), 32'h1);
      check("t5_pre_rst_busy", 32'(busy),     32'h1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy",       32'(busy),       32'h0);
      check("t5_rst_pin_out",    32'(pin_out),    32'h000);
      check("t5_rst_osc_flag",   32'(osc_flag),   32'h0);
      check("t5_rst_break_mask", 32'(break_mask), 32'h000);
      check("t5_rst_toggle_cnt", 32'(toggle_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (139) @(negedge clk);
      run_sweep(8'd8, -1, -1, 140);
      check("t5_done_cyc",   32'(200 + done_cyc), 32'd331);
      check("t5_break_mask", 32'(break_mask),     32'h028);
      check("t5_osc_flag",   32'(osc_flag),       32'h1);
      repeat (3) @(negedge clk);

      // 6: win_len = 0 behaves as a one-cycle window
      obs_mode = 2;
      run_sweep(8'd0, -1, -1, 70);
      check("t6_done_cyc",   32'(done_cyc),   32'd61);
      check("t6_last_busy",  32'(last_busy),  32'd60);
      check("t6_toggle_cnt", 32'(toggle_cnt), 32'd0);
      check("t6_osc_flag",   32'(osc_flag),   32'h0);
      repeat (3) @(negedge clk);

      // 7: longest window, count stays below saturation
      obs_mode = 1;
      run_sweep(8'd255, -1, -1, 2610);
      check("t7_done_cyc",   32'(done_cyc),   32'd2601);
      check("t7_toggle_cnt", 32'(toggle_cnt), 32'd254);
      check("t7_osc_flag",   32'(osc_flag),   32'h1);
      repeat (3) @(negedge clk);

`ifdef LOOP_PIN_SEQ_ABORT_EN
      // 8: abort at cycle 30 during step 2
      obs_mode = 2;
      run_sweep(8'd8, -1, 30, 60);
      check("t8_last_busy",  32'(last_busy),  32'd30);
      check("t8_done_cnt",   32'(done_cnt),   32'd0);
      check("t8_osc_flag",   32'(osc_flag),   32'h0);
      check("t8_break_mask", 32'(break_mask), 32'h000);
      check("t8_toggle_cnt", 32'(toggle_cnt), 32'd0);
      check("t8_pin_out",    32'(pin_log[31]), 32'h000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
